// File: rtl/mem_stage_ctrl_if.sv
// Bundle between mem_stage_ctrl and its neighbours: EX packet input, memory bus, writeback.
// master = mem_stage_ctrl, slave = surrounding pipeline / memory model.
interface mem_stage_ctrl_if #(
  parameter int TAG_W = 4
);
  // EX packet fields presented at the head of the EX output FIFO
  logic [31:0]      ex_pc;
  logic [31:0]      ex_alu_result;
  logic [31:0]      ex_rs2_value;
  logic [4:0]       ex_dest_reg_idx;
  logic             ex_rd_mem;
  logic             ex_wr_mem;
  logic [2:0]       ex_mem_size;
  logic             ex_is_zeroreg;
  logic             ex_halt;
  logic             ex_illegal;

  // A packet transfers on a clock edge where in_valid && in_ready are both high;
  // in_valid may be held while in_ready is low and the packet must stay stable until the transfer.
  logic             in_valid;
  logic             in_ready;

  logic [1:0]       proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [1:0]       proc2mem_size;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  logic             wb_valid;
  logic [4:0]       wb_dest_reg_idx;
  logic [31:0]      wb_value;
  logic [31:0]      wb_PC;
  logic             wb_halt;
  logic             wb_illegal;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    input  ex_pc, ex_alu_result, ex_rs2_value, ex_dest_reg_idx, ex_rd_mem, ex_wr_mem,
           ex_mem_size, ex_is_zeroreg, ex_halt, ex_illegal, in_valid,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output in_ready, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           wb_valid, wb_dest_reg_idx, wb_value, wb_PC, wb_halt, wb_illegal, busy, dbg_state
  );

  modport slave (
    output ex_pc, ex_alu_result, ex_rs2_value, ex_dest_reg_idx, ex_rd_mem, ex_wr_mem,
           ex_mem_size, ex_is_zeroreg, ex_halt, ex_illegal, in_valid,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  in_ready, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           wb_valid, wb_dest_reg_idx, wb_value, wb_PC, wb_halt, wb_illegal, busy, dbg_state
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: one outstanding tagged load/store, single-cycle writeback pulse.
// Optional WAIT watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_stage_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;

  state_t           r_state;
  logic             r_in_ready;

  logic [31:0]      r_pc;
  logic [31:0]      r_alu;
  logic [4:0]       r_dest;
  logic             r_rd_mem;
  logic             r_wr_mem;
  logic [2:0]       r_size;
  logic             r_halt;
  logic             r_illegal;
  logic [TAG_W-1:0] r_tag;

  logic [1:0]       r_cmd;
  logic [31:0]      r_addr;
  logic [63:0]      r_mdata;
  logic [1:0]       r_msize;

  logic             r_wb_valid;
  logic [4:0]       r_wb_dest;
  logic [31:0]      r_wb_value;
  logic [31:0]      r_wb_pc;
  logic             r_wb_halt;
  logic             r_wb_illegal;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    r_timer;
`else
  logic             w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  logic             w_accept;
  logic             w_mem_op;
  logic [63:0]      w_st_data;
  logic             w_tag_hit;
  logic [63:0]      w_line;
  logic [31:0]      w_load_value;
  logic             w_misalign;

  logic             w_retire;
  logic [4:0]       w_ret_dest;
  logic [31:0]      w_ret_value;
  logic [31:0]      w_ret_pc;
  logic             w_ret_halt;
  logic             w_ret_illegal;

  assign w_accept  = bus.in_valid && r_in_ready;
  // exactly one of rd/wr; both set is an illegal packet that never reaches the bus
  assign w_mem_op  = bus.ex_rd_mem ^ bus.ex_wr_mem;
  assign w_st_data = {32'b0, bus.ex_rs2_value} << {bus.ex_alu_result[2:0], 3'b000};
  assign w_tag_hit = (bus.mem2proc_tag != '0) && (bus.mem2proc_tag == r_tag);
  assign w_line    = bus.mem2proc_data >> {r_alu[2:0], 3'b000};

  always_comb begin
    w_load_value = w_line[31:0];
    w_misalign   = (r_alu[2:0] > 3'd4);
    case (r_size[1:0])
      SZ_BYTE: begin
        w_load_value = {{24{~r_size[2] & w_line[7]}}, w_line[7:0]};
        w_misalign   = 1'b0;
      end
      SZ_HALF: begin
        w_load_value = {{16{~r_size[2] & w_line[15]}}, w_line[15:0]};
        w_misalign   = (r_alu[2:0] == 3'd7);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_retire      = 1'b0;
    w_ret_dest    = r_dest;
    w_ret_value   = r_alu;
    w_ret_pc      = r_pc;
    w_ret_halt    = r_halt;
    w_ret_illegal = r_illegal;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_mem_op) begin
          w_retire      = 1'b1;
          w_ret_dest    = (bus.ex_is_zeroreg || bus.ex_wr_mem) ? 5'd0 : bus.ex_dest_reg_idx;
          w_ret_value   = bus.ex_alu_result;
          w_ret_pc      = bus.ex_pc;
          w_ret_halt    = bus.ex_halt;
          w_ret_illegal = bus.ex_illegal | (bus.ex_rd_mem & bus.ex_wr_mem);
        end
      end
      S_REQ: begin
        if ((bus.mem2proc_response != '0) && r_wr_mem) begin
          w_retire = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_tag_hit) begin
          w_retire      = 1'b1;
          w_ret_value   = w_load_value;
          w_ret_illegal = r_illegal | w_misalign;
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_retire      = 1'b1;
          w_ret_value   = 32'd0;
          w_ret_illegal = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b1;
      r_pc         <= '0;
      r_alu        <= '0;
      r_dest       <= '0;
      r_rd_mem     <= 1'b0;
      r_wr_mem     <= 1'b0;
      r_size       <= '0;
      r_halt       <= 1'b0;
      r_illegal    <= 1'b0;
      r_tag        <= '0;
      r_cmd        <= BUS_NONE;
      r_addr       <= '0;
      r_mdata      <= '0;
      r_msize      <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_dest    <= '0;
      r_wb_value   <= '0;
      r_wb_pc      <= '0;
      r_wb_halt    <= 1'b0;
      r_wb_illegal <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      r_timer      <= '0;
`endif
    end else begin
      // wb_* are zero whenever no pulse is being presented
      r_wb_valid   <= w_retire;
      r_wb_dest    <= w_retire ? w_ret_dest    : 5'd0;
      r_wb_value   <= w_retire ? w_ret_value   : 32'd0;
      r_wb_pc      <= w_retire ? w_ret_pc      : 32'd0;
      r_wb_halt    <= w_retire ? w_ret_halt    : 1'b0;
      r_wb_illegal <= w_retire ? w_ret_illegal : 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_pc       <= bus.ex_pc;
            r_alu      <= bus.ex_alu_result;
            r_dest     <= (bus.ex_is_zeroreg || bus.ex_wr_mem) ? 5'd0 : bus.ex_dest_reg_idx;
            r_rd_mem   <= bus.ex_rd_mem;
            r_wr_mem   <= bus.ex_wr_mem;
            r_size     <= bus.ex_mem_size;
            r_halt     <= bus.ex_halt;
            r_illegal  <= bus.ex_illegal;
            if (w_mem_op) begin
              r_state <= S_REQ;
              r_cmd   <= bus.ex_rd_mem ? BUS_LOAD : BUS_STORE;
              r_addr  <= {bus.ex_alu_result[31:3], 3'b000};
              r_mdata <= w_st_data;
              r_msize <= bus.ex_mem_size[1:0];
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          // a zero response leaves the request registers untouched, so it is re-driven as is
          if (bus.mem2proc_response != '0) begin
            r_cmd   <= BUS_NONE;
            r_addr  <= '0;
            r_mdata <= '0;
            r_msize <= '0;
            if (r_rd_mem) begin
              r_tag   <= bus.mem2proc_response;
              r_state <= S_WAIT;
`ifdef MEM_STAGE_TIMEOUT_EN
              r_timer <= '0;
`endif
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (w_tag_hit) begin
            r_tag   <= '0;
            r_state <= S_DONE;
          end
`ifdef MEM_STAGE_TIMEOUT_EN
          else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_tag   <= '0;
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
`endif
        end
        S_DONE: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.proc2mem_command = r_cmd;
  assign bus.proc2mem_addr    = r_addr;
  assign bus.proc2mem_data    = r_mdata;
  assign bus.proc2mem_size    = r_msize;
  assign bus.wb_valid         = r_wb_valid;
  assign bus.wb_dest_reg_idx  = r_wb_dest;
  assign bus.wb_value         = r_wb_value;
  assign bus.wb_PC            = r_wb_pc;
  assign bus.wb_halt          = r_wb_halt;
  assign bus.wb_illegal       = r_wb_illegal;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.dbg_state        = r_state;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: writeback expectations are queued at stimulus time
// and a negedge monitor pops and compares them whenever wb_valid is seen.
module tb_mem_stage_ctrl;
  localparam int EXP_W = 72;  // {care_value, illegal, halt, dest[4:0], pc[31:0], value[31:0]}

  logic clock;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];

  mem_stage_ctrl_if #(.TAG_W(4)) bus ();

  mem_stage_ctrl #(.TAG_W(4), .TIMEOUT_CYCLES(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk_exp(input logic [4:0] dest, input logic [31:0] value,
                                              input logic [31:0] pc, input logic halt,
                                              input logic ill, input logic care);
    return {care, ill, halt, dest, pc, value};
  endfunction

  task automatic set_pkt(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] dest, input logic rd, input logic wr,
                         input logic [2:0] size, input logic zr, input logic halt,
                         input logic ill);
    bus.ex_pc           = pc;
    bus.ex_alu_result   = alu;
    bus.ex_rs2_value    = rs2;
    bus.ex_dest_reg_idx = dest;
    bus.ex_rd_mem       = rd;
    bus.ex_wr_mem       = wr;
    bus.ex_mem_size     = size;
    bus.ex_is_zeroreg   = zr;
    bus.ex_halt         = halt;
    bus.ex_illegal      = ill;
  endtask

  // returns just after the accepting edge
  task automatic send();
    int n = 0;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_wait: in_ready stuck at %b, required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clock);
      if (bus.wb_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_wb: got pc=0x%0h value=0x%0h, required no writeback",
                   bus.wb_PC, bus.wb_value);
        end else begin
          e = exp_q.pop_front();
          if (bus.wb_dest_reg_idx !== e[68:64] || bus.wb_PC !== e[63:32] ||
              bus.wb_halt !== e[69] || bus.wb_illegal !== e[70] ||
              (e[71] && bus.wb_value !== e[31:0])) begin
            n_fail++;
            $display("FAIL wb_compare: got dest=%0d pc=0x%0h value=0x%0h halt=%b ill=%b, required dest=%0d pc=0x%0h value=0x%0h halt=%b ill=%b",
                     bus.wb_dest_reg_idx, bus.wb_PC, bus.wb_value, bus.wb_halt, bus.wb_illegal,
                     e[68:64], e[63:32], e[31:0], e[69], e[70]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset_n               = 1'b0;
    bus.in_valid          = 1'b0;
    bus.mem2proc_response = '0;
    bus.mem2proc_tag      = '0;
    bus.mem2proc_data     = '0;
    set_pkt(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("rst_wb_valid", {63'b0, bus.wb_valid}, 64'd0);
    check("rst_cmd",      {62'b0, bus.proc2mem_command}, 64'd0);
    check("rst_busy",     {63'b0, bus.busy}, 64'd0);
    reset_n = 1'b1;
    tick();

    // ALU pass-through, 1-cycle latency
    set_pkt(32'h100, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_exp(5'd5, 32'h1234, 32'h100, 1'b0, 1'b0, 1'b1));
    send();
    check("alu_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
    check("alu_wb_now",       {63'b0, bus.wb_valid}, 64'd1);

    // back-to-back ALU packets, zero-reg destination on the second
    set_pkt(32'h104, 32'hCAFE, 32'h0, 5'd6, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_exp(5'd6, 32'hCAFE, 32'h104, 1'b0, 1'b0, 1'b1));
    send();
    set_pkt(32'h108, 32'h77, 32'h0, 5'd8, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mk_exp(5'd0, 32'h77, 32'h108, 1'b0, 1'b0, 1'b1));
    send();

    // LB signed with two refused requests
    set_pkt(32'h200, 32'h1003, 32'h0, 5'd7, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    send();
    for (int i = 0; i < 3; i++) begin
      check("lb_cmd",  {62'b0, bus.proc2mem_command}, 64'd1);
      check("lb_addr", {32'b0, bus.proc2mem_addr}, 64'h1000);
      if (i == 2) bus.mem2proc_response = 4'd2;
      tick();
    end
    bus.mem2proc_response = 4'd0;
    check("lb_wait_cmd_none", {62'b0, bus.proc2mem_command}, 64'd0);
    check("lb_wait_state",    {62'b0, bus.dbg_state}, 64'd2);
    repeat (4) tick();
    bus.mem2proc_data = 64'h00000000_80000000;
    bus.mem2proc_tag  = 4'd2;
    exp_q.push_back(mk_exp(5'd7, 32'hFFFFFF80, 32'h200, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem2proc_tag = 4'd0;
    tick();

    // SW at offset 4
    set_pkt(32'h300, 32'h2004, 32'hDEADBEEF, 5'd9, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    send();
    check("sw_cmd",  {62'b0, bus.proc2mem_command}, 64'd2);
    check("sw_addr", {32'b0, bus.proc2mem_addr}, 64'h2000);
    check("sw_data", bus.proc2mem_data, 64'hDEADBEEF_00000000);
    check("sw_size", {62'b0, bus.proc2mem_size}, 64'd2);
    bus.mem2proc_response = 4'd1;
    exp_q.push_back(mk_exp(5'd0, 32'h2004, 32'h300, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem2proc_response = 4'd0;
    check("sw_wb_now", {63'b0, bus.wb_valid}, 64'd1);
    check("sw_cmd_off", {62'b0, bus.proc2mem_command}, 64'd0);
    tick();

    // LW to zero reg, stray tag ignored
    set_pkt(32'h400, 32'h3000, 32'h0, 5'd12, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    send();
    bus.mem2proc_response = 4'd5;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'h11223344_55667788;
    bus.mem2proc_tag      = 4'd7;
    tick();
    bus.mem2proc_tag = 4'd0;
    check("lw_stray_state", {62'b0, bus.dbg_state}, 64'd2);
    bus.mem2proc_tag = 4'd5;
    exp_q.push_back(mk_exp(5'd0, 32'h55667788, 32'h400, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem2proc_tag = 4'd0;
    tick();

    // LH signed at offset 2, LBU at offset 6
    set_pkt(32'h500, 32'h4002, 32'h0, 5'd3, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    send();
    bus.mem2proc_response = 4'd4;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'h00000000_9ABC0000;
    bus.mem2proc_tag      = 4'd4;
    exp_q.push_back(mk_exp(5'd3, 32'hFFFF9ABC, 32'h500, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem2proc_tag = 4'd0;
    set_pkt(32'h504, 32'h5006, 32'h0, 5'd4, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    send();
    bus.mem2proc_response = 4'd6;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'h00F0_0000_0000_0000;
    bus.mem2proc_tag      = 4'd6;
    exp_q.push_back(mk_exp(5'd4, 32'h000000F0, 32'h504, 1'b0, 1'b0, 1'b1));
    tick();
    bus.mem2proc_tag = 4'd0;

    // misaligned LH crossing the line -> illegal, value not checked
    set_pkt(32'h508, 32'h6007, 32'h0, 5'd10, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    send();
    bus.mem2proc_response = 4'd3;
    tick();
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd3;
    exp_q.push_back(mk_exp(5'd10, 32'h0, 32'h508, 1'b0, 1'b1, 1'b0));
    tick();
    bus.mem2proc_tag = 4'd0;

    // bubble with halt/illegal; rd&wr together -> illegal, no bus command
    set_pkt(32'h600, 32'h55, 32'h0, 5'd2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(mk_exp(5'd2, 32'h55, 32'h600, 1'b1, 1'b1, 1'b1));
    send();
    set_pkt(32'h604, 32'h7000, 32'h1, 5'd11, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_exp(5'd0, 32'h7000, 32'h604, 1'b0, 1'b1, 1'b1));
    send();
    check("rdwr_no_cmd", {62'b0, bus.proc2mem_command}, 64'd0);
    tick();

    // reset while in WAIT, late tag ignored
    set_pkt(32'h700, 32'h8000, 32'h0, 5'd13, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    send();
    bus.mem2proc_response = 4'd3;
    tick();
    bus.mem2proc_response = 4'd0;
    check("rw_in_wait", {62'b0, bus.dbg_state}, 64'd2);
    reset_n = 1'b0;
    #1;
    check("rw_state",    {62'b0, bus.dbg_state}, 64'd0);
    check("rw_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("rw_wb_valid", {63'b0, bus.wb_valid}, 64'd0);
    tick();
    reset_n          = 1'b1;
    bus.mem2proc_tag = 4'd3;
    tick();
    bus.mem2proc_tag = 4'd0;
    check("rw_late_tag_wb", {63'b0, bus.wb_valid}, 64'd0);
    tick();

`ifdef MEM_STAGE_TIMEOUT_EN
    // watchdog: LH whose tag never returns
    set_pkt(32'h800, 32'h9000, 32'h0, 5'd14, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    send();
    bus.mem2proc_response = 4'd1;
    tick();
    bus.mem2proc_response = 4'd0;
    repeat (3) tick();
    check("to_not_yet", {63'b0, bus.wb_valid}, 64'd0);
    exp_q.push_back(mk_exp(5'd14, 32'h0, 32'h800, 1'b0, 1'b1, 1'b1));
    tick();
    check("to_wb_now", {63'b0, bus.wb_valid}, 64'd1);
    bus.mem2proc_tag = 4'd1;
    tick();
    bus.mem2proc_tag = 4'd0;
    tick();
`endif

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Downstream consumer of the EX-stage output FIFO. Accepts one EX_PACKET per handshake.
- Issues loads and stores to the tagged, variable-latency memory interface (one outstanding op).
- Produces a single-cycle writeback pulse carrying dest register, value and status.
- Non-memory packets pass through with 1-cycle latency.

Parameters:
- TAG_W, 4, width of memory response/tag (tag 0 = no response).
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ex_packet_in  in  EX_PACKET  packet from the FIFO head.
- in_valid  in  1  packet valid (inverse of the FIFO no_output).
- in_ready  out  1  block accepts the packet this cycle; the FIFO pops on in_valid&&in_ready.
- proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE.
- proc2mem_addr  out  32  8-byte-aligned address, {alu_result[31:3],3'b0}.
- proc2mem_data  out  64  store data: rs2_value shifted left by 8*alu_result[2:0].
- proc2mem_size  out  2  mem_size[1:0] of the held packet.
- mem2proc_response  in  TAG_W  nonzero = request accepted with this tag.
- mem2proc_data  in  64  returned line.
- mem2proc_tag  in  TAG_W  tag of returning data, 0 = none.
- wb_valid  out  1  writeback pulse.
- wb_dest_reg_idx  out  5  destination; forced 0 when is_ZEROREG or store.
- wb_value  out  32  load result or alu_result.
- wb_PC  out  32  PC of the retiring packet.
- wb_halt  out  1  halt flag of the packet.
- wb_illegal  out  1  illegal flag (plus timeout, see the optional feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; held packet cleared; saved tag=0; all outputs 0 except in_ready=1. Deasserting reset mid-operation abandons any request; late tags are ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On accept with rd_mem=wr_mem=0 (incl. valid=0 bubbles with halt/illegal set): latch the packet, go to DONE. wb is visible the next cycle (1-cycle latency).
  - On accept with rd_mem or wr_mem: latch the packet, go to REQ.
  - rd_mem&&wr_mem together: treat as illegal; go to DONE with wb_illegal=1 and no bus command.
- REQ:
  - Drive the command, addr, data and size.
  - mem2proc_response==0: stay in REQ and re-drive the identical request.
  - Nonzero response on a load: save the tag, go to WAIT.
  - Nonzero response on a store: go to DONE (store retires on acceptance).
- WAIT:
  - proc2mem_command=BUS_NONE.
  - When mem2proc_tag==saved tag (nonzero): extract the load and go to DONE.
  - A response whose tag matches in the same cycle as acceptance is impossible by protocol and is not handled.
- Load extraction, with off=alu_result[2:0]:
  - BYTE: data[8*off+:8].
  - HALF: data[8*off+:16].
  - WORD: data[8*off+:32].
  - Sign-extend unless mem_size[2]=1 (unsigned).
  - Misaligned HALF/WORD crossing 8 bytes: set wb_illegal=1; value is don't-care.
- DONE:
  - wb_valid=1 for exactly one cycle; wb_* come from registered state; in_ready=0; next state IDLE.
  - Max throughput: one non-memory packet every 2 cycles.
- Command outputs are 0 outside REQ. wb_* outputs hold 0 when wb_valid=0.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES: go to DONE with wb_illegal=1, wb_value=0; the saved tag is cleared so a late tag is ignored.
  - The counter resets on entry to WAIT.
- Undefined: no counter; WAIT lasts indefinitely.

Test Plan:
- Reset while in WAIT (reset_n low 1 cycle) -> state IDLE, in_ready=1, wb_valid=0; a later mem2proc_tag=3 produces no wb.
- ALU packet, alu_result=0x1234, dest=5, accepted at cycle t -> wb_valid=1 at t+1 with wb_value=0x1234 and dest 5; in_ready=0 at t+1.
- LB, alu_result=0x1003, mem_size=BYTE signed; response 0 for 2 cycles then 2; tag 2 after 5 cycles with data byte3=0x80 -> addr 0x1000 re-driven for 3 cycles, wb_value=0xFFFFFF80.
- SW, alu_result=0x2004, rs2_value=0xDEADBEEF, response=1 -> proc2mem_data=0xDEADBEEF_00000000, wb_valid next cycle, wb_dest_reg_idx=0.
- LW with is_ZEROREG=1 -> load completes normally, wb_dest_reg_idx=0; a stray mem2proc_tag=7 (mismatch) during WAIT is ignored.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=4: LH accepted, tag never returns -> wb_valid 4 cycles after WAIT entry, wb_illegal=1.
